// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - ALU launch / result latch / bus store sequencer
// Optional high-byte transfer for wide results: define ALU_SEQ_HIGH_BYTE_EN.
module alu_seq_ctrl #(
    parameter int ALU_LAT     = 1,
    parameter int BUS_TIMEOUT = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       op_valid,
    input  logic [3:0] op_code,
    input  logic       op_wide,
    output logic       op_ready,
    output logic [3:0] alu_op,
    output logic       alu_start,
    output logic       grab,
    output logic       store,
    output logic       byte_sel,
    output logic       bus_req,
    input  logic       bus_gnt,
    output logic       done,
    output logic       timeout,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_EXEC, S_GRAB, S_REQ, S_STORE_LO, S_STORE_HI
    } state_t;

    localparam logic [3:0] LAT_LAST = 4'(ALU_LAT - 1);
    localparam logic [7:0] TO_LAST  = 8'(BUS_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [3:0] lat_cnt_q, lat_cnt_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic [3:0] alu_op_q, alu_op_d;
    logic       wide_q, wide_d;

`ifndef ALU_SEQ_HIGH_BYTE_EN
    logic unused_op_wide;
    assign unused_op_wide = op_wide;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            lat_cnt_q  <= '0;
            wait_cnt_q <= '0;
            alu_op_q   <= '0;
            wide_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lat_cnt_q  <= lat_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            alu_op_q   <= alu_op_d;
            wide_q     <= wide_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lat_cnt_d  = lat_cnt_q;
        wait_cnt_d = wait_cnt_q;
        alu_op_d   = alu_op_q;
        wide_d     = wide_q;
        op_ready   = 1'b0;
        alu_start  = 1'b0;
        grab       = 1'b0;
        store      = 1'b0;
        byte_sel   = 1'b0;
        bus_req    = 1'b0;
        done       = 1'b0;
        timeout    = 1'b0;
        busy       = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    alu_op_d  = op_code;
`ifdef ALU_SEQ_HIGH_BYTE_EN
                    wide_d    = op_wide;
`else
                    wide_d    = 1'b0;
`endif
                    lat_cnt_d = '0;
                    state_d   = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_start = (lat_cnt_q == 4'd0);
                if (lat_cnt_q == LAT_LAST) begin
                    state_d = S_GRAB;
                end else begin
                    lat_cnt_d = lat_cnt_q + 4'd1;
                end
            end
            S_GRAB: begin
                grab       = 1'b1;
                wait_cnt_d = '0;
                state_d    = S_REQ;
            end
            S_REQ: begin
                bus_req = 1'b1;
                if (bus_gnt) begin
                    wait_cnt_d = '0;
                    state_d    = S_STORE_LO;
                end else if ((BUS_TIMEOUT != 0) && (wait_cnt_q == TO_LAST)) begin
                    timeout = 1'b1;
                    state_d = S_IDLE;
                end else if (wait_cnt_q != 8'hFF) begin
                    // saturate rather than wrap so an unbounded wait stays observable
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            S_STORE_LO: begin
                bus_req = 1'b1;
                store   = bus_gnt;
                if (bus_gnt) begin
                    if (wide_q) begin
                        state_d = S_STORE_HI;
                    end else begin
                        done    = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_STORE_HI: begin
                bus_req = 1'b1;
                store   = bus_gnt;
`ifdef ALU_SEQ_HIGH_BYTE_EN
                byte_sel = 1'b1;
`endif
                if (bus_gnt) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // every control output is quiet while reset is held, whatever the state
        if (reset) begin
            op_ready  = 1'b0;
            alu_start = 1'b0;
            grab      = 1'b0;
            store     = 1'b0;
            byte_sel  = 1'b0;
            bus_req   = 1'b0;
            done      = 1'b0;
            timeout   = 1'b0;
            busy      = 1'b0;
        end
    end

    assign alu_op = alu_op_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - randomized check of alu_seq_ctrl against a transaction-phase model
module tb_alu_seq_ctrl;

`ifdef ALU_SEQ_HIGH_BYTE_EN
    localparam bit HB = 1'b1;
`else
    localparam bit HB = 1'b0;
`endif

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset, op_valid, op_wide, bus_gnt;
    logic [3:0] op_code;
    logic [1:0] op_ready, alu_start, grab, store, byte_sel, bus_req, done, timeout, busy;
    logic [3:0] alu_op0, alu_op1;

    alu_seq_ctrl #(.ALU_LAT(1), .BUS_TIMEOUT(4)) u0 (
        .clock(clock), .reset(reset), .op_valid(op_valid), .op_code(op_code),
        .op_wide(op_wide), .op_ready(op_ready[0]), .alu_op(alu_op0),
        .alu_start(alu_start[0]), .grab(grab[0]), .store(store[0]),
        .byte_sel(byte_sel[0]), .bus_req(bus_req[0]), .bus_gnt(bus_gnt),
        .done(done[0]), .timeout(timeout[0]), .busy(busy[0])
    );

    alu_seq_ctrl #(.ALU_LAT(3), .BUS_TIMEOUT(0)) u1 (
        .clock(clock), .reset(reset), .op_valid(op_valid), .op_code(op_code),
        .op_wide(op_wide), .op_ready(op_ready[1]), .alu_op(alu_op1),
        .alu_start(alu_start[1]), .grab(grab[1]), .store(store[1]),
        .byte_sel(byte_sel[1]), .bus_req(bus_req[1]), .bus_gnt(bus_gnt),
        .done(done[1]), .timeout(timeout[1]), .busy(busy[1])
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // model: an accepted op is described by its age since acceptance,
    // whether it has reached the store phase, which byte is pending, and wait count
    int         m_lat[2];
    int         m_to[2];
    bit         m_busy[2], m_in_store[2], m_hi[2], m_wide[2];
    int         m_age[2], m_waits[2];
    logic [3:0] m_op[2];

    initial begin
        int seg_left;
        int gmode;
        m_lat[0] = 1; m_to[0] = 4;
        m_lat[1] = 3; m_to[1] = 0;
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 0; m_in_store[i] = 0; m_hi[i] = 0; m_wide[i] = 0;
            m_age[i] = 0; m_waits[i] = 0; m_op[i] = 4'h0;
        end
        reset = 1'b1; op_valid = 1'b0; op_code = 4'h0; op_wide = 1'b0; bus_gnt = 1'b0;
        seg_left = 0; gmode = 0;
        repeat (2) @(negedge clock);

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clock);
            if (seg_left == 0) begin
                gmode    = $urandom_range(0, 3);
                seg_left = (gmode == 1) ? $urandom_range(5, 300) : $urandom_range(5, 40);
            end
            seg_left--;
            reset    = (cyc < 2) || ($urandom_range(0, 99) == 0);
            op_valid = $urandom_range(0, 1);
            op_code  = 4'($urandom);
            op_wide  = 1'($urandom);
            case (gmode)
                0:       bus_gnt = 1'b1;
                1:       bus_gnt = 1'b0;
                default: bus_gnt = ($urandom_range(0, 3) != 0);
            endcase
            #1;
            for (int i = 0; i < 2; i++) begin
                bit e_ready, e_start, e_grab, e_store, e_bsel, e_req, e_done, e_to, e_busy, reqph;
                logic [3:0] o_op;
                reqph   = m_busy[i] && (m_age[i] > m_lat[i] + 1) && !m_in_store[i];
                e_ready = !m_busy[i];
                e_busy  = m_busy[i];
                e_start = m_busy[i] && (m_age[i] == 1);
                e_grab  = m_busy[i] && (m_age[i] == m_lat[i] + 1);
                e_req   = reqph || (m_busy[i] && m_in_store[i]);
                e_store = m_busy[i] && m_in_store[i] && bus_gnt;
                e_bsel  = m_busy[i] && m_in_store[i] && m_hi[i];
                e_to    = reqph && !bus_gnt && (m_to[i] != 0) && (m_waits[i] + 1 == m_to[i]);
                e_done  = e_store && (m_hi[i] || !m_wide[i]);
                if (reset) begin
                    e_ready = 0; e_busy = 0; e_start = 0; e_grab = 0; e_req = 0;
                    e_store = 0; e_bsel = 0; e_to = 0; e_done = 0;
                end
                o_op = (i == 0) ? alu_op0 : alu_op1;
                check_eq($sformatf("u%0d.op_ready", i),  32'(op_ready[i]),  32'(e_ready));
                check_eq($sformatf("u%0d.busy", i),      32'(busy[i]),      32'(e_busy));
                check_eq($sformatf("u%0d.alu_start", i), 32'(alu_start[i]), 32'(e_start));
                check_eq($sformatf("u%0d.grab", i),      32'(grab[i]),      32'(e_grab));
                check_eq($sformatf("u%0d.bus_req", i),   32'(bus_req[i]),   32'(e_req));
                check_eq($sformatf("u%0d.store", i),     32'(store[i]),     32'(e_store));
                check_eq($sformatf("u%0d.byte_sel", i),  32'(byte_sel[i]),  32'(e_bsel));
                check_eq($sformatf("u%0d.done", i),      32'(done[i]),      32'(e_done));
                check_eq($sformatf("u%0d.timeout", i),   32'(timeout[i]),   32'(e_to));
                check_eq($sformatf("u%0d.alu_op", i),    32'(o_op),         32'(m_op[i]));

                if (reset) begin
                    m_busy[i] = 0;
                    m_op[i]   = 4'h0;
                end else if (!m_busy[i]) begin
                    if (op_valid) begin
                        m_busy[i] = 1; m_age[i] = 1; m_op[i] = op_code;
                        m_wide[i] = HB && op_wide;
                        m_in_store[i] = 0; m_hi[i] = 0; m_waits[i] = 0;
                    end
                end else begin
                    if (reqph) begin
                        if (bus_gnt)          m_in_store[i] = 1;
                        else if (e_to)        m_busy[i] = 0;
                        else if (m_waits[i] < 255) m_waits[i]++;
                    end else if (m_in_store[i] && bus_gnt) begin
                        if (e_done) m_busy[i] = 0;
                        else        m_hi[i] = 1;
                    end
                    if (m_age[i] < 1000) m_age[i]++;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
